// File: rtl/enemigo_paso_pkg.sv
// Shared Fury on Wheels game definitions: enemy FSM encoding, screen limits
// and the LFSR used to pick spawn lanes.
package enemigo_paso_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SPAWN   = 2'd1,
    MOVE    = 2'd2,
    EXPLODE = 2'd3
  } estado_t;

  localparam logic [9:0]  Y_MAX_PANTALLA = 10'd480;
  localparam int unsigned NUM_CARRILES   = 4;
  localparam int unsigned LANE_W         = $clog2(NUM_CARRILES);

  // Fibonacci taps 8,6,5,4 expressed as register bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/enemigo_paso_sinc_flanco.sv
// Two-flop synchronizer plus rising-edge detector for a slow level that is
// asynchronous to clk_i; one rise_o pulse per low-to-high transition.
module sinc_flanco (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/enemigo_paso.sv
// Enemy car stepper: each rising edge of the slow enemy clock moves the car
// down one step; tracks lane, spawn, collision, explosion and dodge count.
module enemigo_paso
  import enemigo_paso_pkg::*;
#(
  parameter logic [9:0] Y_START    = 10'd0,
  parameter logic [9:0] Y_MAX      = Y_MAX_PANTALLA,
  parameter logic [9:0] STEP       = 10'd4,
  parameter logic [3:0] EXPL_TICKS = 4'd6,
  parameter logic [7:0] SEED       = 8'hA5
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       tick_in,
  input  logic       enable,
  input  logic       hit,
  output logic [9:0] y_pos,
  output logic [1:0] lane,
  output logic       active,
  output logic       exploding,
  output logic       passed,
  output logic [7:0] passed_cnt
);

  estado_t           state_q;
  logic [9:0]        y_q;
  logic [LANE_W-1:0] lane_q;
  logic              active_q, expl_q, passed_q;
  logic [7:0]        cnt_q;
  logic [7:0]        lfsr_q;
  logic [3:0]        ecnt_q;
  logic              tick;
  logic [10:0]       y_sum_d;

  sinc_flanco u_sinc (
    .clk_i  (clock_in),
    .rst_ni (reset_n),
    .d_i    (tick_in),
    .rise_o (tick)
  );

  // 11-bit sum so a step past the bottom cannot wrap below Y_MAX
  assign y_sum_d = {1'b0, y_q} + {1'b0, STEP};

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      y_q      <= Y_START;
      lane_q   <= '0;
      active_q <= 1'b0;
      expl_q   <= 1'b0;
      passed_q <= 1'b0;
      cnt_q    <= '0;
      lfsr_q   <= SEED;
      ecnt_q   <= '0;
    end else begin
      lfsr_q   <= lfsr_next(lfsr_q);
      passed_q <= 1'b0;
      if (!enable) begin
        state_q  <= IDLE;
        y_q      <= Y_START;
        active_q <= 1'b0;
        expl_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            y_q      <= Y_START;
            active_q <= 1'b0;
            expl_q   <= 1'b0;
            state_q  <= SPAWN;
          end
          SPAWN: begin
            lane_q   <= lfsr_q[LANE_W-1:0];
            y_q      <= Y_START;
            active_q <= 1'b1;
            state_q  <= MOVE;
          end
          MOVE: begin
            if (hit) begin
              active_q <= 1'b0;
              expl_q   <= 1'b1;
              ecnt_q   <= '0;
              state_q  <= EXPLODE;
            end else if (tick) begin
              if (y_sum_d >= {1'b0, Y_MAX}) begin
                y_q      <= Y_START;
                active_q <= 1'b0;
                passed_q <= 1'b1;
                if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
                state_q  <= SPAWN;
              end else begin
                y_q <= y_sum_d[9:0];
              end
            end
          end
          EXPLODE: begin
            if (tick) begin
              if (ecnt_q == EXPL_TICKS - 4'd1) begin
                expl_q  <= 1'b0;
                state_q <= SPAWN;
              end else begin
                ecnt_q <= ecnt_q + 4'd1;
              end
            end
          end
        endcase
      end
    end
  end

  assign y_pos      = y_q;
  assign lane       = lane_q;
  assign active     = active_q;
  assign exploding  = expl_q;
  assign passed     = passed_q;
  assign passed_cnt = cnt_q;

endmodule
